// File: rtl/message_scroller.sv
// message_scroller: scrolls a 16-nibble message across a 4-digit multiplexed
// 7-segment display. A 4-nibble window starts at scroll_pos and advances by one
// nibble every SCROLL_DIV clocks, wrapping modulo 16. The message is latched into
// a shadow register on start-up and on every 15->0 wrap, so a window never mixes
// two message versions.
//
// Optional feature: define MSG_SCROLL_PAUSE_EN to add the 'pause' input, which
// freezes the scroll position and scroll counter while display refresh continues.
//
// Interface note: there is no valid/ready handshake here. 'message' is a level
// input that is sampled only on shadow loads. 'pause' is a level input that is
// sampled on every RUN edge.
module message_scroller #(
  parameter int REFRESH_DIV = 4,    // clocks per digit slot, >= 2
  parameter int SCROLL_DIV  = 1024  // clocks per scroll step, >= 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] message,
`ifdef MSG_SCROLL_PAUSE_EN
  input  logic        pause,
`endif
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  scroll_pos
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [SW-1:0] SCROLL_LAST  = SW'(SCROLL_DIV - 1);

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [63:0]     shadow_q, shadow_d;
  logic [RW-1:0]   refresh_cnt_q, refresh_cnt_d;
  logic [SW-1:0]   scroll_cnt_q, scroll_cnt_d;
  logic [1:0]      digit_q, digit_d;
  logic [3:0]      scroll_pos_q, scroll_pos_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;

  logic            hold;
  logic [3:0]      nib_idx;
  logic [3:0]      cur_nib;

`ifdef MSG_SCROLL_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Pick the shadow nibble for the digit being lit: the window wraps modulo 16.
  always_comb begin
    nib_idx = scroll_pos_q + {2'b00, digit_q};
    cur_nib = shadow_q[{nib_idx, 2'b00} +: 4];
  end

  // Next-state logic: LOAD latches the message once, RUN multiplexes and scrolls.
  always_comb begin
    state_d       = state_q;
    shadow_d      = shadow_q;
    refresh_cnt_d = refresh_cnt_q;
    scroll_cnt_d  = scroll_cnt_q;
    digit_d       = digit_q;
    scroll_pos_d  = scroll_pos_q;
    an_d          = an_q;
    seg_d         = seg_q;
    dp_d          = 1'b1;

    case (state_q)
      LOAD: begin
        shadow_d      = message;
        refresh_cnt_d = '0;
        scroll_cnt_d  = '0;
        digit_d       = 2'd0;
        an_d          = 4'b1111;
        seg_d         = 7'b1111111;
        state_d       = RUN;
      end

      RUN: begin
        // Digit slot: light on count 0, blank on the last count before moving
        // to the next digit so the segment change never ghosts onto a neighbour.
        if (refresh_cnt_q == '0) begin
          an_d          = ~(4'b1000 >> digit_q);
          seg_d         = seg_decode(cur_nib);
          refresh_cnt_d = refresh_cnt_q + RW'(1);
        end else if (refresh_cnt_q == REFRESH_LAST) begin
          an_d          = 4'b1111;
          digit_d       = digit_q + 2'd1;
          refresh_cnt_d = '0;
        end else begin
          refresh_cnt_d = refresh_cnt_q + RW'(1);
        end

        // Scroll step. The display above already used the pre-edge position and
        // shadow, so a new window only shows from the next digit slot.
        if (!hold) begin
          if (scroll_cnt_q == SCROLL_LAST) begin
            scroll_cnt_d = '0;
            scroll_pos_d = scroll_pos_q + 4'd1;
            if (scroll_pos_q == 4'hF) begin
              shadow_d = message;
            end
          end else begin
            scroll_cnt_d = scroll_cnt_q + SW'(1);
          end
        end
      end

      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // State and datapath registers, asynchronously cleared to a blank display.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= LOAD;
      shadow_q      <= '0;
      refresh_cnt_q <= '0;
      scroll_cnt_q  <= '0;
      digit_q       <= 2'd0;
      scroll_pos_q  <= 4'd0;
      an_q          <= 4'b1111;
      seg_q         <= 7'b1111111;
      dp_q          <= 1'b1;
    end else begin
      state_q       <= state_d;
      shadow_q      <= shadow_d;
      refresh_cnt_q <= refresh_cnt_d;
      scroll_cnt_q  <= scroll_cnt_d;
      digit_q       <= digit_d;
      scroll_pos_q  <= scroll_pos_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign scroll_pos = scroll_pos_q;

endmodule
